// File: rtl/mips_core_pkg.sv
// Shared types and helpers for the cache-side AXI line responder.
package mips_core_pkg;

    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_LEN_WIDTH  = 4;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_DATA = 3'd1,
        W_RESP = 3'd2,
        R_WAIT = 3'd3,
        R_DATA = 3'd4
    } axi_resp_state_t;

    // LEN carries the beat count itself; the all-zero code stands for a full 16-beat line.
    function automatic logic [4:0] len_to_beats(input logic [AXI_LEN_WIDTH-1:0] len);
        if (len == 4'd0) begin
            return 5'd16;
        end else begin
            return {1'b0, len};
        end
    endfunction

endpackage

// File: rtl/cache_bank.sv
// Synchronous 1R1W word store; read data appears the cycle after the address.
module cache_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array and registered read port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_line_responder.sv
// One-transaction-at-a-time AXI burst slave serving cache line flushes and refills
// from an on-chip word memory; the five AXI channel bundles are flattened into ports.
module axi_line_responder
    import mips_core_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 14,
    parameter int READ_LATENCY   = 4,
    parameter int DATA_WIDTH     = AXI_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [AXI_ID_WIDTH-1:0]   awid_i,
    input  logic [AXI_LEN_WIDTH-1:0]  awlen_i,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    input  logic [AXI_ID_WIDTH-1:0]   wid_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic                      wlast_i,
    output logic                      bvalid_o,
    input  logic                      bready_i,
    output logic [AXI_ID_WIDTH-1:0]   bid_o,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    input  logic [AXI_ID_WIDTH-1:0]   arid_i,
    input  logic [AXI_LEN_WIDTH-1:0]  arlen_i,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [AXI_ID_WIDTH-1:0]   rid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      rlast_o,
    output logic                      proto_err
);

    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);
    localparam logic [3:0] LAT_LAST = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

    axi_resp_state_t           state_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [4:0]                beats_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [3:0]                lat_q;
    logic                      wready_q;
    logic                      bvalid_q;
    logic                      rvalid_q;
    logic                      rlast_q;
    logic [AXI_ID_WIDTH-1:0]   bid_q;
    logic [AXI_ID_WIDTH-1:0]   rid_q;
    logic                      proto_err_q;

    logic                      aw_start_s;
    logic                      ar_start_s;
    logic                      w_beat_s;
    logic                      w_end_s;
    logic                      r_beat_s;
    logic [MEM_ADDR_WIDTH-1:0] aw_word_s;
    logic [MEM_ADDR_WIDTH-1:0] ar_word_s;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr_d;
    logic [DATA_WIDTH-1:0]     bank_rdata_s;
    logic                      unused_addr_s;

    // Write wins a same-cycle tie so a dirty-line flush always lands before its refill.
    assign aw_start_s = (state_q == IDLE) && !rst && awvalid_i;
    assign ar_start_s = (state_q == IDLE) && !rst && arvalid_i && !awvalid_i;
    assign w_beat_s   = wready_q && wvalid_i;
    assign w_end_s    = wlast_i || (beats_q == 5'd1);
    assign r_beat_s   = rvalid_q && rready_i;
    assign aw_word_s  = awaddr_i[MEM_ADDR_WIDTH+1:2];
    assign ar_word_s  = araddr_i[MEM_ADDR_WIDTH+1:2];

    assign unused_addr_s = ^{awaddr_i[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], awaddr_i[1:0],
                             araddr_i[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], araddr_i[1:0], wid_i};

    // Bank read address runs one beat ahead so the word is waiting when RVALID rises or advances.
    always_comb begin
        rd_addr_d = addr_q;
        case (state_q)
            IDLE: begin
                rd_addr_d = ar_word_s;
            end
            R_DATA: begin
                if (r_beat_s) begin
                    rd_addr_d = addr_q + ADDR_ONE;
                end else begin
                    rd_addr_d = addr_q;
                end
            end
            default: begin
                rd_addr_d = addr_q;
            end
        endcase
    end

    cache_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_bank (
        .clk    (clk),
        .we_i   (w_beat_s),
        .waddr_i(addr_q),
        .wdata_i(wdata_i),
        .raddr_i(rd_addr_d),
        .rdata_o(bank_rdata_s)
    );

    // Transaction FSM with its registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beats_q     <= 5'd0;
            id_q        <= '0;
            lat_q       <= 4'd0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            bid_q       <= '0;
            rid_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aw_start_s) begin
                        id_q     <= awid_i;
                        beats_q  <= len_to_beats(awlen_i);
                        addr_q   <= aw_word_s;
                        wready_q <= 1'b1;
                        state_q  <= W_DATA;
                    end else if (ar_start_s) begin
                        id_q    <= arid_i;
                        beats_q <= len_to_beats(arlen_i);
                        addr_q  <= ar_word_s;
                        lat_q   <= 4'd0;
                        if (READ_LATENCY == 1) begin
                            rvalid_q <= 1'b1;
                            rid_q    <= arid_i;
                            rlast_q  <= (len_to_beats(arlen_i) == 5'd1);
                            state_q  <= R_DATA;
                        end else begin
                            state_q <= R_WAIT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                W_DATA: begin
                    if (w_beat_s) begin
                        addr_q  <= addr_q + ADDR_ONE;
                        beats_q <= beats_q - 5'd1;
                        if (w_end_s) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            state_q  <= W_RESP;
                            if (wlast_i != (beats_q == 5'd1)) begin
                                proto_err_q <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_q <= 1'b0;
                        bid_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                R_WAIT: begin
                    lat_q <= lat_q + 4'd1;
                    if (lat_q >= LAT_LAST) begin
                        rvalid_q <= 1'b1;
                        rid_q    <= id_q;
                        rlast_q  <= (beats_q == 5'd1);
                        state_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_beat_s) begin
                        if (beats_q == 5'd1) begin
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                            rid_q    <= '0;
                            state_q  <= IDLE;
                        end else begin
                            addr_q  <= addr_q + ADDR_ONE;
                            beats_q <= beats_q - 5'd1;
                            rlast_q <= (beats_q == 5'd2);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign awready_o = aw_start_s;
    assign arready_o = ar_start_s;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bid_o     = bid_q;
    assign rvalid_o  = rvalid_q;
    assign rid_o     = rid_q;
    assign rlast_o   = rlast_q;
    assign rdata_o   = rvalid_q ? bank_rdata_s : '0;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_line_responder.sv
// Directed bench for axi_line_responder: stimulus tasks queue expected R/B responses,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_axi_line_responder;

    localparam int MAW = 14;
    localparam int LAT = 4;
    localparam int WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast, proto_err;
    logic [3:0]  awid, awlen, wid, bid, arid, arlen, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic        last;
    } r_exp_t;

    r_exp_t      r_q[$];
    logic [3:0]  b_q[$];
    logic [31:0] model [0:WORDS-1];
    r_exp_t      r_e;
    logic [3:0]  b_e;

    always #5 clk = ~clk;

    axi_line_responder #(
        .MEM_ADDR_WIDTH(MAW),
        .READ_LATENCY  (LAT),
        .DATA_WIDTH    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .awvalid_i(awvalid),
        .awready_o(awready),
        .awid_i   (awid),
        .awlen_i  (awlen),
        .awaddr_i (awaddr),
        .wvalid_i (wvalid),
        .wready_o (wready),
        .wid_i    (wid),
        .wdata_i  (wdata),
        .wlast_i  (wlast),
        .bvalid_o (bvalid),
        .bready_i (bready),
        .bid_o    (bid),
        .arvalid_i(arvalid),
        .arready_o(arready),
        .arid_i   (arid),
        .arlen_i  (arlen),
        .araddr_i (araddr),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .rid_o    (rid),
        .rdata_o  (rdata),
        .rlast_o  (rlast),
        .proto_err(proto_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic int beats_of(input logic [3:0] len);
        return (len == 4'd0) ? 16 : int'(len);
    endfunction

    // Scoreboard monitor: every accepted R or B beat must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (r_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got beat %h expected none", rdata);
            end else begin
                r_e = r_q.pop_front();
                chk("r_data", rdata, r_e.data);
                chk("r_id", {28'd0, rid}, {28'd0, r_e.id});
                chk1("r_last", rlast, r_e.last);
            end
        end
        if (!rst && bvalid && bready) begin
            if (b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got bid %h expected none", bid);
            end else begin
                b_e = b_q.pop_front();
                chk("b_id", {28'd0, bid}, {28'd0, b_e});
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                             input int wlast_at, input logic [31:0] base);
        int nb;
        int sent;
        int word;
        nb   = beats_of(len);
        sent = (wlast_at < nb) ? wlast_at : nb;
        word = int'(addr[15:2]);
        for (int k = 0; k < sent; k++) model[(word + k) % WORDS] = base + 32'(k);
        b_q.push_back(id);
        awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
        @(negedge clk);
        chk1("aw_ready", awready, 1'b1);
        chk1("ar_blocked", arready, 1'b0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k < sent; k++) begin
            wvalid = 1'b1;
            wid    = id;
            wdata  = base + 32'(k);
            wlast  = (k + 1 == wlast_at);
            @(negedge clk);
            chk1("w_ready", wready, 1'b1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        chk1("b_timing", bvalid, 1'b1);
        chk1("w_ready_off", wready, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                            input logic stall);
        int nb;
        int word;
        int done;
        int cyc;
        logic [31:0] held;
        logic hold_pend;
        nb   = beats_of(len);
        word = int'(addr[15:2]);
        for (int k = 0; k < nb; k++) r_q.push_back('{model[(word + k) % WORDS], id, logic'(k == nb - 1)});
        arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
        @(negedge clk);
        chk1("ar_ready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            if (c == LAT - 1) chk1("r_early", rvalid, 1'b0);
            @(posedge clk); #1;
        end
        done = 0;
        cyc = 0;
        hold_pend = 1'b0;
        held = 32'd0;
        while (done < nb && cyc < 200) begin
            rready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (cyc == 0) chk1("r_latency", rvalid, 1'b1);
            if (hold_pend) chk("r_hold", rdata, held);
            hold_pend = rvalid && !rready;
            held = rdata;
            if (rvalid && rready) done++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("r_beats", 32'(done), 32'(nb));
        rready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        awvalid = 1'b1; awid = 4'd0; awlen = 4'd0; awaddr = 32'd0;
        wvalid = 1'b0; wid = 4'd0; wdata = 32'd0; wlast = 1'b0; bready = 1'b1;
        arvalid = 1'b0; arid = 4'd0; arlen = 4'd0; araddr = 32'd0; rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_awready", awready, 1'b0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_arready", arready, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_rlast", rlast, 1'b0);
        chk("rst_rid", {28'd0, rid}, 32'd0);
        chk("rst_bid", {28'd0, bid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk1("rst_proto_err", proto_err, 1'b0);
        awvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        axi_write(32'h0000_0100, 4'd4, 4'd3, 4, 32'h0000_00A0);
        chk1("proto_err_clean", proto_err, 1'b0);
        axi_read(32'h0000_0100, 4'd4, 4'd5, 1'b0);

        arvalid = 1'b1; araddr = 32'h0000_0100; arlen = 4'd4; arid = 4'd6;
        axi_write(32'h0000_0100, 4'd4, 4'd2, 4, 32'h0000_00B0);
        axi_read(32'h0000_0100, 4'd4, 4'd6, 1'b0);

        axi_write(32'h0000_0200, 4'd8, 4'd7, 8, 32'h0000_00C0);
        axi_read(32'h0000_0200, 4'd8, 4'd8, 1'b1);

        axi_write(32'h0000_FFFC, 4'd0, 4'd9, 16, 32'h0000_00D0);
        axi_read(32'h0000_FFFC, 4'd0, 4'd10, 1'b0);

        axi_write(32'h0000_0300, 4'd4, 4'd11, 2, 32'h0000_00E0);
        chk1("proto_err_set", proto_err, 1'b1);
        axi_read(32'h0000_0300, 4'd2, 4'd12, 1'b0);
        chk1("proto_err_sticky", proto_err, 1'b1);

        arvalid = 1'b1; araddr = 32'h0000_0100; arlen = 4'd4; arid = 4'd13;
        @(negedge clk);
        chk1("rst_ar_ready", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready  = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rst_pre_rvalid", rvalid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("rst_mid_rvalid", rvalid, 1'b0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_rid", {28'd0, rid}, 32'd0);
        chk1("rst_mid_proto_err", proto_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        rready = 1'b1;
        axi_read(32'h0000_0100, 4'd4, 4'd14, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_r_drain", 32'(r_q.size()), 32'd0);
        chk("sb_b_drain", 32'(b_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
